pingpong_round_logger: RTL and testbench

- Downstream observer of the two-counter handshaking stage. Consumes the two 4-bit counter outputs c1/c2 and segments their activity into "runs": maximal stretches where only one counter increments.
- Each completed run is logged as a record into a small FIFO, drained over a valid/ready interface.
- Also flags protocol violations (both counters moving, illegal steps) and stalls (no activity for too long).

---
 rtl/pingpong_round_logger.sv | 103 ++++++++++
 tb/tb_pingpong_round_logger.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_round_logger.sv
// pingpong_round_logger: splits c1/c2 counter activity into single-counter runs,
// logs each finished run into a record FIFO and flags protocol errors and stalls.
module pingpong_round_logger #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  c1,
  input  logic [3:0]  c2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_data,
  output logic        err_both,
  output logic        err_step,
  output logic        stall,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {PRIME, IDLE, RUN1, RUN2} state_t;
  state_t state, state_nx;
  logic [3:0] p1, p2, r_start, r_end;
  logic r_src;
  logic [7:0] r_len;
  logic [IW-1:0] idle_cnt;
  logic d1, d2, ok1, ok2, active, in_run, bad_both, bad_step, err, quiet, timeout;
  logic open_run, extend, push, pop, accept;
  logic [AW:0] count;
  logic [AW-1:0] wptr, rptr;
  logic [16:0] mem [DEPTH];
  always_comb begin
    d1 = c1 != p1;
    d2 = c2 != p2;
    ok1 = c1 == p1 + 4'd1;
    ok2 = c2 == p2 + 4'd1;
    active = state != PRIME;
    in_run = state == RUN1 || state == RUN2;
    bad_both = active && d1 && d2;
    bad_step = active && ((d1 && !ok1) || (d2 && !ok2));
    err = bad_both || bad_step;
    quiet = !d1 && !d2;
    timeout = in_run && quiet && idle_cnt == IW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk)
    if (!rst) state <= PRIME;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == PRIME || err) state_nx = IDLE;
    else if (d1) state_nx = RUN1;
    else if (d2) state_nx = RUN2;
    else if (timeout) state_nx = IDLE;
  end
  // A change on the counter that is not currently running closes the run and starts the other one.
  always_comb begin
    extend = !err && ((state == RUN1 && d1) || (state == RUN2 && d2));
    open_run = active && !err && !quiet && !extend;
    push = in_run && (err || open_run || timeout);
    pop = out_valid && out_ready;
    accept = push && (count < (AW+1)'(DEPTH) || pop);
    out_valid = count != '0;
    out_data = out_valid ? mem[rptr] : '0;
  end
  always_ff @(posedge clk) begin
    p1 <= c1;
    p2 <= c2;
    if (!rst) begin
      r_src <= 1'b0;
      r_start <= '0;
      r_end <= '0;
      r_len <= '0;
      idle_cnt <= '0;
      stall <= 1'b0;
      err_both <= 1'b0;
      err_step <= 1'b0;
      drop_cnt <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (open_run) begin
        r_src <= d2;
        r_start <= d2 ? p2 : p1;
        r_end <= d2 ? c2 : c1;
        r_len <= 8'd1;
      end else if (extend) begin
        r_end <= d2 ? c2 : c1;
        r_len <= r_len + 8'(r_len != 8'hff);
      end
      idle_cnt <= (in_run && quiet && !timeout) ? idle_cnt + 1'b1 : '0;
      stall <= timeout;
      err_both <= err_both | bad_both;
      err_step <= err_step | bad_step;
      drop_cnt <= drop_cnt + 8'(push && !accept && drop_cnt != 8'hff);
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      wptr <= wptr + AW'(accept);
      rptr <= rptr + AW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (accept) mem[wptr] <= {r_src, r_start, r_end, r_len};
endmodule

// File: tb/tb_pingpong_round_logger.sv
// tb_pingpong_round_logger: directed stimulus with a scoreboard queue of expected records.
module tb_pingpong_round_logger;
  logic clk = 1'b0, rst = 1'b0, out_ready = 1'b0;
  logic [3:0] c1 = 4'd0, c2 = 4'd0;
  logic out_valid, err_both, err_step, stall;
  logic [16:0] out_data;
  logic [7:0] drop_cnt;
  logic [16:0] exp_q [$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pingpong_round_logger dut (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err_both(err_both), .err_step(err_step), .stall(stall), .drop_cnt(drop_cnt)
  );
  function automatic logic [16:0] rec(input logic s, input logic [3:0] st, input logic [3:0] en, input logic [7:0] len);
    return {s, st, en, len};
  endfunction
  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [3:0] a, input logic [3:0] b);
    c1 = a;
    c2 = b;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
  endtask
  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 17'(out_valid), 17'd0);
      else chk("pop_record", out_data, exp_q.pop_front());
    end
  initial begin
    tick();
    tick();
    chk("rst_valid", 17'(out_valid), 17'd0);
    chk("rst_data", out_data, 17'd0);
    chk("rst_err_both", 17'(err_both), 17'd0);
    chk("rst_err_step", 17'(err_step), 17'd0);
    chk("rst_stall", 17'(stall), 17'd0);
    chk("rst_drop", 17'(drop_cnt), 17'd0);
    rst = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      set(4'(i), 4'd0);
      chk("basic_no_valid", 17'(out_valid), 17'd0);
    end
    exp_q.push_back(rec(0, 0, 5, 5));
    set(4'd5, 4'd1);
    chk("basic_valid", 17'(out_valid), 17'd1);
    chk("basic_data", out_data, rec(0, 0, 5, 5));
    out_ready = 1'b1;
    for (int i = 2; i <= 6; i++) set(4'd5, 4'(i));
    exp_q.push_back(rec(1, 0, 6, 6));
    set(4'd6, 4'd6);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) exp_q.push_back(rec(0, 5, 6, 1));
      set(4'd6, 4'd6);
      chk("pp_stall", 17'(stall), 17'(i == 16));
    end
    tick();
    chk("pp_stall_after", 17'(stall), 17'd0);
    tick();
    chk("pp_drained", 17'(exp_q.size()), 17'd0);
    c1 = 4'd14;
    c2 = 4'd6;
    do_reset();
    set(4'd15, 4'd6);
    set(4'd0, 4'd6);
    set(4'd1, 4'd6);
    exp_q.push_back(rec(0, 14, 1, 3));
    set(4'd1, 4'd7);
    chk("wrap_err_step", 17'(err_step), 17'd0);
    for (int i = 2; i <= 300; i++) set(4'd1, 4'((6 + i) % 16));
    exp_q.push_back(rec(1, 6, 2, 255));
    set(4'd2, 4'd2);
    set(4'd3, 4'd2);
    exp_q.push_back(rec(0, 1, 3, 2));
    set(4'd4, 4'd3);
    chk("both_err_both", 17'(err_both), 17'd1);
    chk("both_err_step", 17'(err_step), 17'd0);
    for (int i = 0; i < 20; i++) set(4'd4, 4'd3);
    chk("both_idle_no_stall", 17'(stall), 17'd0);
    chk("both_sticky", 17'(err_both), 17'd1);
    chk("both_drained", 17'(exp_q.size()), 17'd0);
    set(4'd5, 4'd3);
    set(4'd6, 4'd3);
    exp_q.push_back(rec(0, 4, 6, 2));
    set(4'd10, 4'd3);
    chk("jump_err_step", 17'(err_step), 17'd1);
    tick();
    tick();
    chk("jump_drained", 17'(exp_q.size()), 17'd0);
    out_ready = 1'b0;
    c1 = 4'd0;
    c2 = 4'd0;
    do_reset();
    chk("bp_rst_err_both", 17'(err_both), 17'd0);
    set(4'd1, 4'd0);
    exp_q.push_back(rec(0, 0, 1, 1));
    set(4'd1, 4'd1);
    exp_q.push_back(rec(1, 0, 1, 1));
    set(4'd2, 4'd1);
    chk("bp_hold_a", out_data, rec(0, 0, 1, 1));
    exp_q.push_back(rec(0, 1, 2, 1));
    set(4'd2, 4'd2);
    exp_q.push_back(rec(1, 1, 2, 1));
    set(4'd3, 4'd2);
    set(4'd3, 4'd3);
    chk("bp_hold_b", out_data, rec(0, 0, 1, 1));
    set(4'd4, 4'd3);
    chk("bp_valid", 17'(out_valid), 17'd1);
    chk("bp_hold_c", out_data, rec(0, 0, 1, 1));
    chk("bp_drop", 17'(drop_cnt), 17'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_drained", 17'(exp_q.size()), 17'd0);
    chk("bp_empty", 17'(out_valid), 17'd0);
    out_ready = 1'b0;
    exp_q.push_back(rec(0, 3, 4, 1));
    set(4'd4, 4'd4);
    exp_q.push_back(rec(1, 3, 4, 1));
    set(4'd5, 4'd4);
    exp_q.push_back(rec(0, 4, 5, 1));
    set(4'd5, 4'd5);
    exp_q.push_back(rec(1, 4, 5, 1));
    set(4'd6, 4'd5);
    out_ready = 1'b1;
    exp_q.push_back(rec(0, 5, 6, 1));
    set(4'd6, 4'd6);
    chk("full_pushpop_drop", 17'(drop_cnt), 17'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("full_drained", 17'(exp_q.size()), 17'd0);
    chk("full_drop_final", 17'(drop_cnt), 17'd2);
    out_ready = 1'b0;
    set(4'd7, 4'd6);
    set(4'd7, 4'd7);
    chk("mid_queued", 17'(out_valid), 17'd1);
    rst = 1'b0;
    tick();
    chk("mid_valid", 17'(out_valid), 17'd0);
    chk("mid_data", out_data, 17'd0);
    chk("mid_err_both", 17'(err_both), 17'd0);
    chk("mid_err_step", 17'(err_step), 17'd0);
    chk("mid_stall", 17'(stall), 17'd0);
    chk("mid_drop", 17'(drop_cnt), 17'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    set(4'd9, 4'd7);
    chk("prime_err_step", 17'(err_step), 17'd0);
    chk("prime_valid", 17'(out_valid), 17'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("prime_no_record", 17'(out_valid), 17'd0);
    chk("prime_err_both", 17'(err_both), 17'd0);
    chk("prime_err_step_late", 17'(err_step), 17'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
